// File: rtl/mmio_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_stack_pkg
// Description : Shared defaults and derived widths for the MMIO stack.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_stack_pkg;

    localparam int c_default_width = 16;
    localparam int c_default_depth = 16;

    // count must represent 0..DEPTH inclusive, hence one bit above the index
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int c_default_count_width = count_width(c_default_depth);

endpackage
`default_nettype wire

// File: rtl/mmio_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_stack_if
// Description : CPU-side bus bundle of the MMIO stack peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_stack_if
    import mmio_stack_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DEPTH = c_default_depth
);
    localparam int c_count_width = count_width(DEPTH);

    logic                     sel;
    logic                     write;
    logic                     read;
    logic                     clr;
    logic [WIDTH-1:0]         dataIn;
    logic [WIDTH-1:0]         dataOut;
    logic [c_count_width-1:0] count;
    logic                     empty;
    logic                     full;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output sel, write, read, clr, dataIn,
        input  dataOut, count, empty, full, overflow, underflow
    );

    modport slave (
        input  sel, write, read, clr, dataIn,
        output dataOut, count, empty, full, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/mmio_stack_mem.sv
`default_nettype none
// ============================================================================
// Module      : stack_mem
// Description : DEPTH x WIDTH register array, sync write / async read.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_mem
    import mmio_stack_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DEPTH = c_default_depth
) (
    input  wire logic                     CLK,
    input  wire logic                     we,
    input  wire logic [$clog2(DEPTH)-1:0] waddr,
    input  wire logic [WIDTH-1:0]         wdata,
    input  wire logic [$clog2(DEPTH)-1:0] raddr,
    output      logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // No reset: entries are always written before the top level consumes them
    always_ff @(posedge CLK) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/mmio_stack.sv
`default_nettype none
// ============================================================================
// Module      : mmio_stack
// Description : Memory-mapped LIFO with registered top-of-stack and sticky
//               overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_stack
    import mmio_stack_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DEPTH = c_default_depth
) (
    input wire logic    CLK,
    input wire logic    RST,
    mmio_stack_if.slave bus
);

    localparam int c_cw = count_width(DEPTH);
    localparam int c_aw = $clog2(DEPTH);

    localparam logic [c_cw-1:0] c_zero       = '0;
    localparam logic [c_cw-1:0] c_one        = c_cw'(1);
    localparam logic [c_cw-1:0] c_two        = c_cw'(2);
    localparam logic [c_cw-1:0] c_full_count = c_cw'(DEPTH);

    logic [c_cw-1:0]  r_count;
    logic [WIDTH-1:0] r_data;
    logic             r_overflow;
    logic             r_underflow;

    logic [c_cw-1:0]  w_count_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_overflow_nxt;
    logic             w_underflow_nxt;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_we;
    logic [c_aw-1:0]  w_waddr;
    logic [c_aw-1:0]  w_top_idx;
    logic [c_aw-1:0]  w_raddr;
    logic [WIDTH-1:0] w_rdata;
    logic [c_cw-1:0]  w_count_m1;
    logic [c_cw-1:0]  w_count_m2;

    assign w_push  = bus.sel & bus.write;
    assign w_pop   = bus.sel & bus.read;
    assign w_empty = (r_count == c_zero);
    assign w_full  = (r_count == c_full_count);

    assign w_count_m1 = r_count - c_one;
    assign w_count_m2 = r_count - c_two;
    assign w_top_idx  = w_count_m1[c_aw-1:0];
    // Entry just below the current top becomes visible after a pop
    assign w_raddr    = w_count_m2[c_aw-1:0];

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (bus.dataIn),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    always_comb begin
        w_count_nxt     = r_count;
        w_data_nxt      = r_data;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;
        w_we            = 1'b0;
        w_waddr         = r_count[c_aw-1:0];

        if (bus.clr) begin
            w_count_nxt     = c_zero;
            w_data_nxt      = '0;
            w_overflow_nxt  = 1'b0;
            w_underflow_nxt = 1'b0;
        end else if (w_push && w_pop && !w_empty) begin
            // Replace top in place; also the path for push+pop while full
            w_we       = 1'b1;
            w_waddr    = w_top_idx;
            w_data_nxt = bus.dataIn;
        end else if (w_push) begin
            if (!w_full) begin
                w_we        = 1'b1;
                w_count_nxt = r_count + c_one;
                w_data_nxt  = bus.dataIn;
            end else begin
                w_overflow_nxt = 1'b1;
            end
        end else if (w_pop) begin
            if (!w_empty) begin
                w_count_nxt = w_count_m1;
                w_data_nxt  = (r_count == c_one) ? '0 : w_rdata;
            end else begin
                w_underflow_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count     <= c_zero;
            r_data      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_data      <= w_data_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    assign bus.dataOut   = r_data;
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_mmio_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_stack
// Description : Self-checking bench for mmio_stack against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_stack;
    import mmio_stack_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    mmio_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    mmio_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] m_q [$];
    bit               m_ovf;
    bit               m_udf;

    function automatic logic [31:0] m_top();
        if (m_q.size() == 0) return 32'h0;
        return 32'(m_q[m_q.size()-1]);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic w, input logic r,
                              input logic c, input logic [WIDTH-1:0] d);
        if (c) begin
            model_reset();
        end else if (s) begin
            if (w && r && m_q.size() > 0) begin
                m_q[m_q.size()-1] = d;
            end else if (w) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else                    m_ovf = 1'b1;
            end else if (r) begin
                if (m_q.size() > 0) void'(m_q.pop_back());
                else                m_udf = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},     32'(bus.count),     32'(m_q.size()));
        check({tag, ".dataOut"},   32'(bus.dataOut),   m_top());
        check({tag, ".empty"},     32'(bus.empty),     32'(m_q.size() == 0));
        check({tag, ".full"},      32'(bus.full),      32'(m_q.size() == DEPTH));
        check({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
        check({tag, ".underflow"}, 32'(bus.underflow), 32'(m_udf));
    endtask

    // Drive one bus cycle; outputs must not move before the edge
    task automatic cyc(input logic s, input logic w, input logic r, input logic c,
                       input logic [WIDTH-1:0] d, input string tag);
        bus.sel    = s;
        bus.write  = w;
        bus.read   = r;
        bus.clr    = c;
        bus.dataIn = d;
        #1;
        check({tag, ".pre_dataOut"}, 32'(bus.dataOut), m_top());
        check({tag, ".pre_count"},   32'(bus.count),   32'(m_q.size()));
        @(posedge CLK);
        model_step(s, w, r, c, d);
        #1;
        check_all(tag);
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input string tag);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, d, tag);
    endtask

    task automatic pop(input string tag);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, WIDTH'($urandom), tag);
    endtask

    task automatic clear(input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, WIDTH'($urandom), tag);
    endtask

    initial begin
        bus.sel    = 1'b0;
        bus.write  = 1'b0;
        bus.read   = 1'b0;
        bus.clr    = 1'b0;
        bus.dataIn = '0;
        RST        = 1'b1;
        model_reset();

        repeat (2) @(posedge CLK);
        #2;
        check_all("reset");
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;
        check_all("post_reset");

        // Basic push/pop ordering
        push(16'h1111, "b_push1");
        push(16'h2222, "b_push2");
        push(16'h3333, "b_push3");
        pop("b_pop1");
        pop("b_pop2");
        pop("b_pop3");

        // Underflow then clear
        pop("uf_pop");
        pop("uf_pop2");
        clear("uf_clr");

        // Fill to capacity and overflow
        for (int i = 0; i < DEPTH; i++) push(WIDTH'(i), "fill");
        push(16'hBEEF, "ovf_push");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h5A5A, "full_pushpop");
        clear("ovf_clr");

        // Simultaneous push/pop on empty and non-empty stacks
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h7777, "pp_empty");
        clear("pp_clr");
        push(16'hAAAA, "pp_a");
        push(16'hBBBB, "pp_b");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'hCCCC, "pp_replace");
        pop("pp_pop");

        // clr wins over push
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h4444, "clr_prio");

        // Deselected activity is ignored
        push(16'h0101, "sel_seed");
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, WIDTH'($urandom), "sel_low");

        // Asynchronous reset between edges with count=5
        clear("ar_clr");
        for (int i = 0; i < 5; i++) push(WIDTH'($urandom), "ar_fill");
        #3 RST = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        #1 RST = 1'b0;
        push(16'h1234, "ar_push");

        // Randomised traffic: push-heavy phase then pop-heavy phase
        for (int i = 0; i < 400; i++) begin
            logic s, w, r, c;
            s = ($urandom % 8) != 0;
            if (i < 200) begin
                w = ($urandom % 4) != 0;
                r = ($urandom % 4) == 0;
            end else begin
                w = ($urandom % 4) == 0;
                r = ($urandom % 4) != 0;
            end
            c = ($urandom % 60) == 0;
            cyc(s, w, r, c, WIDTH'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
